// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
//   Multiply/divide unit sitting beside the ALU in the EX stage. Runs
//   mult/multu/div/divu over a fixed latency into private HI/LO registers and
//   serves mthi/mtlo writes while idle.
//
//   Handshake: Start is a one-cycle request qualified by MDOp in 1..4. It is
//   accepted on the rising edge where Start_o (= Start & ~Busy) is high and
//   MDOp is an arithmetic op; a request seen while Busy is dropped, never
//   queued.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   Start    in   EX-stage instruction is mult/multu/div/divu
//   MDOp     in   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 rsvd
//   A, B     in   operands (A is also the mthi/mtlo source)
//   Start_o  out  Start & ~Busy
//   Busy     out  operation in flight (registered)
//   HI, LO   out  architectural HI/LO registers
//   state_o  out  FSM state (0 idle, 1 run) for observation
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start_o,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        state_o
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic             state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      res_q, res_d;
    logic             wr_q, wr_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0] a_sx, b_sx, mul_s, mul_u;
    logic [31:0] a_mag, b_mag, s_den, u_den;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic        b_zero, is_arith, accept;

    // Result datapath, evaluated on the operands present at Start.
    always_comb begin
        // Low 64 bits of the product of sign-extended operands is the
        // signed 64-bit product.
        a_sx  = {{32{A[31]}}, A};
        b_sx  = {{32{B[31]}}, B};
        mul_s = a_sx * b_sx;
        mul_u = {32'd0, A} * {32'd0, B};

        b_zero = (B == 32'd0);
        // Signed division on magnitudes avoids the 0x80000000 / -1 overflow
        // case: |0x80000000| fits in 32 unsigned bits and negates back to
        // itself, which is the required quotient.
        a_mag = A[31] ? (~A + 32'd1) : A;
        b_mag = B[31] ? (~B + 32'd1) : B;
        // Divisor forced to 1 on divide-by-zero; the result is discarded.
        s_den = b_zero ? 32'd1 : b_mag;
        u_den = b_zero ? 32'd1 : B;
        q_mag = a_mag / s_den;
        r_mag = a_mag % s_den;
        q_s   = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s   = A[31] ? (~r_mag + 32'd1) : r_mag;
        q_u   = A / u_den;
        r_u   = A % u_den;
    end

    assign is_arith = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
    assign accept   = Start && (state_q == ST_IDLE) && is_arith;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        res_d   = res_q;
        wr_d    = wr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    case (MDOp)
                        OP_MULT:  res_d = mul_s;
                        OP_MULTU: res_d = mul_u;
                        OP_DIV:   res_d = {r_s, q_s};
                        default:  res_d = {r_u, q_u};
                    endcase
                    // A divide by zero still runs full latency but leaves
                    // HI/LO untouched at completion.
                    wr_d    = !(((MDOp == OP_DIV) || (MDOp == OP_DIVU)) && b_zero);
                    count_d = ((MDOp == OP_MULT) || (MDOp == OP_MULTU))
                              ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end else if (!Start && (MDOp == OP_MTHI)) begin
                    hi_d = A;
                end else if (!Start && (MDOp == OP_MTLO)) begin
                    lo_d = A;
                end
            end
            default: begin
                // count_q == 1 here means this edge takes it to zero.
                if (count_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    wr_d    = 1'b0;
                    if (wr_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            res_q   <= '0;
            wr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy    = (state_q == ST_RUN);
    assign Start_o = Start & ~Busy;
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    logic        clk;
    logic        reset_n;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        Start_o, Busy, state_o;
    logic [31:0] HI, LO;
    logic        start_o1, busy1, state1;
    logic [31:0] hi1, lo1;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_hi, m_lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .clk(clk), .reset_n(reset_n), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .Start_o(Start_o), .Busy(Busy), .HI(HI), .LO(LO), .state_o(state_o)
    );

    // Minimum-latency instance sharing the same stimulus.
    md_unit #(.MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .Start_o(start_o1), .Busy(busy1), .HI(hi1), .LO(lo1), .state_o(state1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Independent reference: 64-bit signed arithmetic, no overflow cases.
    function automatic logic [63:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: md_model = sa * sb;
            3'd2: md_model = ua * ub;
            3'd3: begin
                if (b == 32'd0) md_model = {hi, lo};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    md_model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) md_model = {hi, lo};
                else md_model = {a % b, a / b};
            end
        endcase
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge of the first idle cycle so
    // consecutive calls exercise back-to-back acceptance.
    // inj: 0 none, 1 Start mid-run, 2 mtlo mid-run.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int lat, input int inj);
        int n, n1;
        logic chk1;
        Start = 1'b1; MDOp = op; A = a; B = b;
        #1 check_eq({tag, "_start_o"}, {31'd0, Start_o}, 32'd1);
        exp_q.push_back(eh);
        exp_q.push_back(el);
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0; A = $urandom; B = $urandom;
        n = 0; n1 = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            if (busy1 === 1'b1) n1++;
            if (n == 1) check_eq({tag, "_hi_hold"}, HI, m_hi);
            if (n == 3) check_eq({tag, "_lo_hold"}, LO, m_lo);
            if (n == 2 && inj == 1) begin
                Start = 1'b1; MDOp = 3'd3; A = 32'h0000_0064; B = 32'h0000_0003;
                #1 check_eq({tag, "_start_o_busy"}, {31'd0, Start_o}, 32'd0);
            end
            if (n == 2 && inj == 2) begin
                MDOp = 3'd6; A = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            Start = 1'b0; MDOp = 3'd0;
        end
        check_eq({tag, "_busy_cycles"}, n, lat);
        if (exp_q.size() < 2) begin
            check_eq({tag, "_queue"}, exp_q.size(), 2);
        end else begin
            m_hi = exp_q.pop_front();
            m_lo = exp_q.pop_front();
            check_eq({tag, "_hi"}, HI, m_hi);
            check_eq({tag, "_lo"}, LO, m_lo);
        end
        chk1 = (inj != 1) && !((op == 3'd3 || op == 3'd4) && b == 32'd0);
        if (inj != 1) check_eq({tag, "_min_busy"}, n1, 1);
        if (chk1) begin
            check_eq({tag, "_min_hi"}, hi1, eh);
            check_eq({tag, "_min_lo"}, lo1, el);
        end
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] val);
        MDOp = op; A = val;
        @(posedge clk);
        @(negedge clk);
        MDOp = 3'd0;
        if (op == 3'd5) m_hi = val; else m_lo = val;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] r;
        logic [2:0]  op;
        logic [31:0] ra, rb;
        reset_n = 1'b0; Start = 1'b0; MDOp = 3'd0; A = '0; B = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", {31'd0, Busy}, 32'd0);
        check_eq("rst_hi", HI, 32'd0);
        check_eq("rst_lo", LO, 32'd0);
        check_eq("rst_start_o", {31'd0, Start_o}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0);
        do_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, 0);
        do_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
        do_op("divu", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 10, 0);

        do_mt(3'd5, 32'h1234_5678);
        check_eq("mthi", HI, 32'h1234_5678);
        do_op("start_mid", 3'd1, 32'd7, 32'd6, 32'd0, 32'd42, 5, 1);

        do_mt(3'd5, 32'h0000_00AA);
        do_mt(3'd6, 32'h0000_00BB);
        check_eq("mtlo", LO, 32'h0000_00BB);
        do_op("div0", 3'd3, 32'd1234, 32'd0, 32'h0000_00AA, 32'h0000_00BB, 10, 2);
        do_op("divu0", 3'd4, 32'd99, 32'd0, 32'h0000_00AA, 32'h0000_00BB, 10, 0);
        do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0);

        // Ignored requests: non-arithmetic Start, MDOp 0/7.
        Start = 1'b1; MDOp = 3'd5; A = 32'h5555_5555;
        @(posedge clk); @(negedge clk);
        Start = 1'b0; MDOp = 3'd7; A = 32'h6666_6666;
        @(posedge clk); @(negedge clk);
        MDOp = 3'd0;
        check_eq("ign_busy", {31'd0, Busy}, 32'd0);
        check_eq("ign_hi", HI, m_hi);
        check_eq("ign_lo", LO, m_lo);

        // Reset in the middle of a div (count at 3).
        Start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd7;
        @(posedge clk); @(negedge clk);
        Start = 1'b0; MDOp = 3'd0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("abort_busy", {31'd0, Busy}, 32'd0);
        check_eq("abort_hi", HI, 32'd0);
        check_eq("abort_lo", LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (12) @(negedge clk);
        check_eq("abort_late_busy", {31'd0, Busy}, 32'd0);
        check_eq("abort_late_hi", HI, 32'd0);
        check_eq("abort_late_lo", LO, 32'd0);
        do_op("post_rst", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5, 0);

        // Random back-to-back traffic against the reference model.
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            r  = md_model(op, ra, rb, m_hi, m_lo);
            do_op($sformatf("rnd%0d", i), op, ra, rb, r[63:32], r[31:0],
                  (op <= 3'd2) ? 5 : 10, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
